// File: rtl/pc_unit_if.sv
// Fetch-stage PC bus: control requests into pc_unit and fetch address/status back out.
interface pc_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 32
);
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              exc_req;
    logic              halt_req;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus;
    logic              fetch_valid;
    logic              halted;
    logic              misalign_err;
    logic [CNT_W-1:0]  fetch_count;

    modport master (
        output stall, redirect_valid, redirect_addr, exc_req, halt_req,
        input  pc, pc_plus, fetch_valid, halted, misalign_err, fetch_count
    );

    modport slave (
        input  stall, redirect_valid, redirect_addr, exc_req, halt_req,
        output pc, pc_plus, fetch_valid, halted, misalign_err, fetch_count
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential stepping, redirect/exception vectoring with fixed
// priority, redirect buffering across stalls, halt state and a fetch counter.
module pc_unit #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'(32'h0000_0080),
    parameter int unsigned       INC        = 4,
    parameter int unsigned       ALIGN_BITS = 2,
    parameter int unsigned       CNT_W      = 32
) (
    input  logic     clk,
    input  logic     reset,
    pc_unit_if.slave bus
);

    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INC);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              misalign_q, misalign_d;
    logic [CNT_W-1:0]  count_q;

    logic [ADDR_W-1:0] target_c;
    logic              target_misaligned_c;
    logic              fetch_valid_c;

    assign target_c            = bus.redirect_addr & ~LOW_MASK;
    assign target_misaligned_c = |(bus.redirect_addr & LOW_MASK);
    assign fetch_valid_c       = (state_q == ST_RUN) && !bus.stall;

    // Next-state / next-PC selection, highest priority first.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        misalign_d   = 1'b0;

        if (bus.exc_req) begin
            pc_d         = EXC_VEC;
            pend_valid_d = 1'b0;
            state_d      = ST_RUN;
        end else begin
            case (state_q)
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                ST_BOOT: begin
                    state_d = ST_RUN;
                    // PC is not yet fetching, so any redirect is parked until RUN.
                    if (bus.redirect_valid) begin
                        pend_addr_d  = target_c;
                        pend_valid_d = 1'b1;
                        misalign_d   = target_misaligned_c;
                    end
                end
                ST_RUN: begin
                    if (bus.redirect_valid && bus.stall) begin
                        pend_addr_d  = target_c;
                        pend_valid_d = 1'b1;
                        misalign_d   = target_misaligned_c;
                    end else if (bus.redirect_valid) begin
                        pc_d         = target_c;
                        pend_valid_d = 1'b0;
                        misalign_d   = target_misaligned_c;
                    end else if (pend_valid_q && !bus.stall) begin
                        pc_d         = pend_addr_q;
                        pend_valid_d = 1'b0;
                    end else if (!bus.stall) begin
                        if (bus.halt_req) begin
                            state_d = ST_HALT;
                        end else begin
                            pc_d = pc_q + STEP;
                        end
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VEC;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            misalign_q   <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            misalign_q   <= misalign_d;
            if (fetch_valid_c) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus      = pc_q + STEP;
    assign bus.fetch_valid  = fetch_valid_c;
    assign bus.halted       = (state_q == ST_HALT);
    assign bus.misalign_err = misalign_q;
    assign bus.fetch_count  = count_q;

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised fetch-stage program counter for the pipelined MIPS core, sitting in front of instruction memory. It generates the fetch address each cycle, applies branch/jump redirects and exception vectoring with fixed priority, buffers a redirect that arrives during a stall, supports a halt state, and counts issued fetches.

## Interface
- ADDR_W, 32, PC and address width
- RESET_VEC, 0, PC value loaded on reset
- EXC_VEC, 32'h0000_0080, PC value loaded on exception
- INC, 4, sequential increment; power of two
- ALIGN_BITS, 2, log2(INC); low address bits forced to zero on redirect
- CNT_W, 32, fetch counter width
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold PC; no fetch issued
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_addr  in  ADDR_W  redirect target
- exc_req  in  1  exception; vector to EXC_VEC
- halt_req  in  1  stop fetching after this cycle
- pc  out  ADDR_W  current fetch address (registered)
- pc_plus  out  ADDR_W  pc + INC (combinational, mod 2^ADDR_W)
- fetch_valid  out  1  pc is being fetched this cycle
- halted  out  1  state is HALT
- misalign_err  out  1  one-cycle registered pulse: accepted redirect had nonzero low bits
- fetch_count  out  CNT_W  number of cycles with fetch_valid=1

## Operation
- States: BOOT, RUN, HALT. Reset: state=BOOT, pc=RESET_VEC, pending_valid=0, pending_addr=0, misalign_err=0, fetch_count=0; hence fetch_valid=0, halted=0, pc_plus=RESET_VEC+INC.
- BOOT: fetch_valid=0; pc held; next edge -> RUN. exc_req and redirects are handled as in RUN (exception moves to RUN with EXC_VEC; redirect captured as pending).
- fetch_valid = (state==RUN) & ~stall. halted = (state==HALT).
- Redirect target = redirect_addr with low ALIGN_BITS cleared. Accepted redirect (applied or captured) with nonzero low bits -> misalign_err=1 next cycle only.
- Next-PC priority, evaluated each edge, highest first:
  1. exc_req (any state, stall ignored): pc<=EXC_VEC, pending_valid<=0, state<=RUN.
  2. HALT without exc_req: everything held; redirect_valid, halt_req, stall ignored.
  3. redirect_valid & stall: pc held; pending_addr<=target, pending_valid<=1 (newer redirect overwrites older).
  4. redirect_valid & ~stall: pc<=target; pending_valid<=0.
  5. pending_valid & ~stall: pc<=pending_addr; pending_valid<=0.
  6. ~stall (RUN): pc<=pc+INC, wraps modulo 2^ADDR_W.
  7. stall: pc held.
- halt_req in RUN with ~stall and no exc_req/redirect: state<=HALT, pc held (not incremented); this cycle's fetch still counts. halt_req with stall, redirect or exception: ignored.
- fetch_count increments on every edge where fetch_valid=1; wraps at 2^CNT_W.

## Timing
- Redirect/exception applied at edge: target visible on pc the following cycle (1-cycle latency).
- Redirect under stall: target on pc one cycle after the first non-stalled edge.
- pc_plus follows pc combinationally, zero latency.
- Reset assertion mid-operation: immediately (asynchronously) returns all state to reset values, discards pending redirect; first fetch_valid two cycles after reset deasserts (BOOT cycle, then RUN).
- exc_req and redirect_valid same cycle: exception wins, redirect dropped.
- pc=2^ADDR_W-INC sequential step -> pc=0, no error.

## Test plan
- Reset release, stall=0 -> cycle 0 BOOT fetch_valid=0 pc=0; then pc=0,4,8,12 with fetch_valid=1; fetch_count=4 after four RUN cycles.
- At pc=0x10 redirect_valid=1, redirect_addr=0x200 -> next pc=0x200, then 0x204; redirect_addr=0x203 -> pc=0x200, misalign_err high exactly one cycle.
- stall=1 for 3 cycles with redirect to 0x400 in stall cycle 1 and 0x500 in cycle 2 -> pc held, fetch_valid=0, count frozen; on release pc=0x500 next cycle, then 0x504.
- exc_req with redirect_valid same cycle, stall=1 -> pc=0x80, pending cleared, next pc 0x84 once stall drops.
- halt_req at pc=0x40 -> halted=1, pc stays 0x40, fetch_valid=0, redirects ignored; exc_req -> pc=0x80, RUN.
- Reset asserted mid-stall with pending redirect; and ADDR_W=8, pc=0xFC -> pc wraps to 0x00; reset clears pending, pc=RESET_VEC.
